// File: rtl/hdma_mover_if.sv
// Signal bundle between the HDMA sequencer, system bus mux and VRAM port and the HDMA data mover.
// master = mover side (drives bus/VRAM strobes), slave = the surrounding system.
interface hdma_mover_if;
    logic        hdma_rd;
    logic [15:0] hdma_source_addr;
    logic [15:0] hdma_target_addr;
    logic        vram_bank;
    logic [7:0]  bus_din;
    logic        bus_rd;
    logic [15:0] bus_addr;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic        vram_bank_out;
    logic [7:0]  vram_dout;
    logic        cpu_stall;
    logic        block_done;

    modport master (
        input  hdma_rd, hdma_source_addr, hdma_target_addr, vram_bank, bus_din,
        output bus_rd, bus_addr, vram_we, vram_addr, vram_bank_out, vram_dout,
               cpu_stall, block_done
    );

    modport slave (
        output hdma_rd, hdma_source_addr, hdma_target_addr, vram_bank, bus_din,
        input  bus_rd, bus_addr, vram_we, vram_addr, vram_bank_out, vram_dout,
               cpu_stall, block_done
    );
endinterface

// File: rtl/hdma_mover.sv
// HDMA/GDMA byte mover: bus read -> capture -> VRAM write, one byte per 2 clk, write 3 clk after launch.
// No backpressure: bus and VRAM take every strobe; the CPU is stalled while a transfer or drain is in flight.
module hdma_mover (
    input  logic         clk,
    input  logic         reset,
    hdma_mover_if.master io
);
    logic        phase;
    logic        launch;
    logic        src_is_vram;
    logic [15:0] src_mapped;

    logic        rd_vld, rd_vsrc, rd_bank;
    logic [12:0] rd_tgt;
    logic        cap_vld, cap_vsrc, cap_bank;
    logic [12:0] cap_tgt;
    logic        wr_vld;
    logic [3:0]  blk_cnt;

    logic [15:0] bus_addr_q;
    logic [12:0] vram_addr_q;
    logic [7:0]  vram_dout_q;
    logic        vram_bank_q;
    logic        stall;

    logic unused_tgt_hi;
    assign unused_tgt_hi = ^io.hdma_target_addr[15:13];

    // Phase 0 marks the first cycle of each byte slot; forced low whenever the sequencer is idle.
    assign launch = io.hdma_rd & ~phase;

    always_comb begin
        src_is_vram = (io.hdma_source_addr[15:13] == 3'b100);
        src_mapped  = io.hdma_source_addr;
        if (io.hdma_source_addr[15:13] == 3'b111) begin
            src_mapped[14] = 1'b0;   // echo RAM reads go to 0xA000-0xBFFF
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= 1'b0;
            rd_vld      <= 1'b0;
            rd_vsrc     <= 1'b0;
            rd_bank     <= 1'b0;
            rd_tgt      <= 13'd0;
            cap_vld     <= 1'b0;
            cap_vsrc    <= 1'b0;
            cap_bank    <= 1'b0;
            cap_tgt     <= 13'd0;
            wr_vld      <= 1'b0;
            blk_cnt     <= 4'd0;
            bus_addr_q  <= 16'h0000;
            vram_addr_q <= 13'd0;
            vram_dout_q <= 8'h00;
            vram_bank_q <= 1'b0;
        end else begin
            phase <= io.hdma_rd ? ~phase : 1'b0;

            rd_vld <= launch;
            if (launch) begin
                rd_vsrc <= src_is_vram;
                rd_tgt  <= io.hdma_target_addr[12:0];
                rd_bank <= io.vram_bank;
                if (!src_is_vram) begin
                    bus_addr_q <= src_mapped;
                end
            end

            cap_vld <= rd_vld;
            if (rd_vld) begin
                cap_vsrc <= rd_vsrc;
                cap_tgt  <= rd_tgt;
                cap_bank <= rd_bank;
            end

            // bus_din is valid in the cycle after bus_rd, so it is taken here.
            wr_vld <= cap_vld;
            if (cap_vld) begin
                vram_addr_q <= cap_tgt;
                vram_dout_q <= cap_vsrc ? 8'hFF : io.bus_din;
                vram_bank_q <= cap_bank;
            end

            if (!stall) begin
                blk_cnt <= 4'd0;
            end else if (wr_vld) begin
                blk_cnt <= blk_cnt + 4'd1;
            end
        end
    end

    assign stall            = io.hdma_rd | rd_vld | cap_vld | wr_vld;
    assign io.cpu_stall     = stall;
    assign io.bus_rd        = rd_vld & ~rd_vsrc;
    assign io.bus_addr      = bus_addr_q;
    assign io.vram_we       = wr_vld;
    assign io.vram_addr     = vram_addr_q;
    assign io.vram_dout     = vram_dout_q;
    assign io.vram_bank_out = vram_bank_q;
    assign io.block_done    = wr_vld & (blk_cnt == 4'hF);
endmodule

// File: tb/tb_hdma_mover.sv
// Bench for hdma_mover: directed single-byte table, corner sequences, and random traffic vs an event model.
module tb_hdma_mover;
    localparam int MAXC = 600;

    logic clk = 1'b0;
    logic reset;
    hdma_mover_if bus_if();

    hdma_mover dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus_if)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  xor_mode = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ (xor_mode ? a[15:8] : 8'h00);
    endfunction

    function automatic logic [15:0] map_src(input logic [15:0] a);
        return (a >= 16'hE000) ? (a - 16'h4000) : a;
    endfunction

    function automatic bit is_vram(input logic [15:0] a);
        return (a >= 16'h8000) && (a < 16'hA000);
    endfunction

    // Bus memory: answers a read in the following cycle, junk otherwise.
    always @(posedge clk)
        bus_if.bus_din <= bus_if.bus_rd ? mem_byte(bus_if.bus_addr) : 8'($urandom);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step_drive(input logic rd, input logic [15:0] src, input logic [15:0] tgt,
                              input logic bank);
        @(posedge clk);
        #1;
        bus_if.hdma_rd          = rd;
        bus_if.hdma_source_addr = src;
        bus_if.hdma_target_addr = tgt;
        bus_if.vram_bank        = bank;
    endtask

    // Stimulus and observation per cycle
    logic        s_rd[MAXC];
    logic [15:0] s_src[MAXC], s_tgt[MAXC];
    logic        s_bank[MAXC];
    logic        o_rd[MAXC], o_we[MAXC], o_vbank[MAXC], o_stall[MAXC], o_done[MAXC];
    logic [15:0] o_baddr[MAXC];
    logic [12:0] o_vaddr[MAXC];
    logic [7:0]  o_vdat[MAXC];

    task automatic run_seq(input int n_drive, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < n_drive) step_drive(s_rd[k], s_src[k], s_tgt[k], s_bank[k]);
            else             step_drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
            @(negedge clk);
            o_rd[k]    = bus_if.bus_rd;
            o_baddr[k] = bus_if.bus_addr;
            o_we[k]    = bus_if.vram_we;
            o_vaddr[k] = bus_if.vram_addr;
            o_vdat[k]  = bus_if.vram_dout;
            o_vbank[k] = bus_if.vram_bank_out;
            o_stall[k] = bus_if.cpu_stall;
            o_done[k]  = bus_if.block_done;
        end
    endtask

    // Reference: each launched byte is an event list (read at +1, write at +3, stall +0..+3).
    task automatic model_check(input int n_drive, input int n, input string name,
                               output int n_wr, output int n_rdc, output int n_done,
                               output int n_stall);
        logic        e_rd[MAXC], e_we[MAXC], e_vbank[MAXC], e_stall[MAXC], e_done[MAXC];
        logic [15:0] e_baddr[MAXC];
        logic [12:0] e_vaddr[MAXC];
        logic [7:0]  e_vdat[MAXC];
        logic [41:0] ev, av;
        int run = 0;
        int cnt = 0;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_we[c] = 0; e_vbank[c] = 0; e_stall[c] = 0; e_done[c] = 0;
            e_baddr[c] = 0; e_vaddr[c] = 0; e_vdat[c] = 0;
        end
        for (int c = 0; c < n_drive; c++) begin
            if (s_rd[c]) begin
                e_stall[c] = 1;
                if (run % 2 == 0) begin
                    for (int d = 0; d < 4; d++) e_stall[c+d] = 1;
                    if (!is_vram(s_src[c])) begin
                        e_rd[c+1]    = 1;
                        e_baddr[c+1] = map_src(s_src[c]);
                    end
                    e_we[c+3]    = 1;
                    e_vaddr[c+3] = s_tgt[c][12:0];
                    e_vdat[c+3]  = is_vram(s_src[c]) ? 8'hFF : mem_byte(map_src(s_src[c]));
                    e_vbank[c+3] = s_bank[c];
                end
                run++;
            end else begin
                run = 0;
            end
        end
        for (int c = 0; c < n; c++) begin
            if (e_we[c]) begin
                e_done[c] = (cnt == 15);
                cnt = (cnt + 1) % 16;
            end
            if (!e_stall[c]) cnt = 0;
        end
        n_wr = 0; n_rdc = 0; n_done = 0; n_stall = 0;
        for (int c = 0; c < n; c++) begin
            ev = {e_rd[c], e_rd[c] ? e_baddr[c] : 16'h0, e_we[c],
                  e_we[c] ? {e_vaddr[c], e_vdat[c], e_vbank[c]} : 22'h0, e_stall[c], e_done[c]};
            av = {o_rd[c], e_rd[c] ? o_baddr[c] : 16'h0, o_we[c],
                  e_we[c] ? {o_vaddr[c], o_vdat[c], o_vbank[c]} : 22'h0, o_stall[c], o_done[c]};
            check($sformatf("%s cycle %0d", name, c), 64'(av), 64'(ev));
            if (c > 0 && o_we[c] && o_we[c-1])
                check($sformatf("%s back-to-back vram_we at %0d", name, c), 1, 0);
            n_wr    += int'(o_we[c]);
            n_rdc   += int'(o_rd[c]);
            n_done  += int'(o_done[c]);
            n_stall += int'(o_stall[c]);
        end
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] tgt;
        logic        bank;
        logic        exp_rd;
        logic [15:0] exp_baddr;
        logic [7:0]  exp_dat;
        logic [12:0] exp_vaddr;
    } vec_t;

    initial begin
        vec_t vt[8];
        int nw, nr, nd, ns;

        vt[0] = '{16'h2040, 16'h8200, 1'b0, 1'b1, 16'h2040, 8'h60, 13'h0200};
        vt[1] = '{16'hE010, 16'h9FF0, 1'b1, 1'b1, 16'hA010, 8'hB0, 13'h1FF0};
        vt[2] = '{16'h8800, 16'h8001, 1'b0, 1'b0, 16'hA010, 8'hFF, 13'h0001};
        vt[3] = '{16'h7FFF, 16'h9000, 1'b1, 1'b1, 16'h7FFF, 8'h80, 13'h1000};
        vt[4] = '{16'h9FFF, 16'h8010, 1'b1, 1'b0, 16'h7FFF, 8'hFF, 13'h0010};
        vt[5] = '{16'hFFFF, 16'h8ABC, 1'b0, 1'b1, 16'hBFFF, 8'h40, 13'h0ABC};
        vt[6] = '{16'hA000, 16'h8000, 1'b1, 1'b1, 16'hA000, 8'hA0, 13'h0000};
        vt[7] = '{16'hDFFF, 16'h9234, 1'b0, 1'b1, 16'hDFFF, 8'h20, 13'h1234};

        reset = 1'b1;
        bus_if.hdma_rd = 0; bus_if.hdma_source_addr = 0; bus_if.hdma_target_addr = 0;
        bus_if.vram_bank = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset strobes {bus_rd,we,stall,done}",
              {bus_if.bus_rd, bus_if.vram_we, bus_if.cpu_stall, bus_if.block_done}, 4'b0);
        check("reset data {bus_addr,vram_addr,dout,bank}",
              {bus_if.bus_addr, bus_if.vram_addr, bus_if.vram_dout, bus_if.vram_bank_out}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single one-cycle launches: latency, remapping, bank capture, hold behaviour.
        xor_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_drive(1'b1, vt[i].src, vt[i].tgt, vt[i].bank);
            @(negedge clk);
            check($sformatf("vec%0d C0 {stall,bus_rd,we}", i),
                  {bus_if.cpu_stall, bus_if.bus_rd, bus_if.vram_we}, 3'b100);
            step_drive(1'b0, 16'($urandom), 16'($urandom), ~vt[i].bank);
            @(negedge clk);
            check($sformatf("vec%0d C1 bus_rd", i), bus_if.bus_rd, vt[i].exp_rd);
            check($sformatf("vec%0d C1 bus_addr", i), bus_if.bus_addr, vt[i].exp_baddr);
            step_drive(1'b0, 16'($urandom), 16'($urandom), ~vt[i].bank);
            @(negedge clk);
            check($sformatf("vec%0d C2 {bus_rd,we,stall}", i),
                  {bus_if.bus_rd, bus_if.vram_we, bus_if.cpu_stall}, 3'b001);
            step_drive(1'b0, 16'($urandom), 16'($urandom), ~vt[i].bank);
            @(negedge clk);
            check($sformatf("vec%0d C3 {we,done,addr,dat,bank}", i),
                  {bus_if.vram_we, bus_if.block_done, bus_if.vram_addr, bus_if.vram_dout,
                   bus_if.vram_bank_out},
                  {1'b1, 1'b0, vt[i].exp_vaddr, vt[i].exp_dat, vt[i].bank});
            step_drive(1'b0, 16'($urandom), 16'($urandom), ~vt[i].bank);
            @(negedge clk);
            check($sformatf("vec%0d C4 {stall,we,held dat}", i),
                  {bus_if.cpu_stall, bus_if.vram_we, bus_if.vram_dout}, {2'b00, vt[i].exp_dat});
        end

        // GDMA of 32 bytes, bus data = low address byte.
        xor_mode = 1'b0;
        for (int k = 0; k < 64; k++) begin
            s_rd[k] = 1; s_src[k] = 16'h2040 + 16'(k / 2); s_tgt[k] = 16'h8200 + 16'(k / 2);
            s_bank[k] = 0;
        end
        run_seq(64, 72);
        model_check(64, 72, "gdma32", nw, nr, nd, ns);
        check("gdma32 writes", nw, 32);
        check("gdma32 block_done pulses", nd, 2);
        check("gdma32 last data", o_vdat[65], 8'h5F);

        // hdma_rd dropped in phase 1 of byte 5.
        xor_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            s_rd[k] = (k < 9); s_src[k] = 16'h3000 + 16'(k / 2); s_tgt[k] = 16'h8400 + 16'(k / 2);
            s_bank[k] = 1;
        end
        run_seq(12, 18);
        model_check(12, 18, "abort", nw, nr, nd, ns);
        check("abort writes", nw, 5);
        check("abort reads", nr, 5);

        // Re-rise during drain, then 0x7FFF -> 0x8000 within one transfer.
        for (int k = 0; k < 14; k++) begin
            s_rd[k] = (k != 3 && k != 6 && k != 8 && k < 10);
            s_src[k] = (k < 10) ? 16'h4000 + 16'(k) : 16'h0;
            s_tgt[k] = 16'h8100 + 16'(k); s_bank[k] = k[0];
        end
        run_seq(14, 20);
        model_check(14, 20, "rerise", nw, nr, nd, ns);
        check("rerise writes", nw, 5);
        for (int k = 0; k < 4; k++) begin
            s_rd[k] = 1; s_src[k] = (k < 2) ? 16'h7FFF : 16'h8000; s_tgt[k] = 16'h8300 + 16'(k / 2);
            s_bank[k] = 0;
        end
        run_seq(4, 10);
        model_check(4, 10, "vram_edge", nw, nr, nd, ns);
        check("vram_edge reads", nr, 1);

        // Reset asserted in C2 of a single-byte transfer.
        step_drive(1'b1, 16'h2345, 16'h8777, 1'b1);
        step_drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midreset C3 strobes {bus_rd,we,stall,done}",
              {bus_if.bus_rd, bus_if.vram_we, bus_if.cpu_stall, bus_if.block_done}, 4'b0);
        check("midreset C3 data {bus_addr,vram_addr,dout,bank}",
              {bus_if.bus_addr, bus_if.vram_addr, bus_if.vram_dout, bus_if.vram_bank_out}, 0);
        @(posedge clk); @(negedge clk);
        check("midreset C4 vram_we", bus_if.vram_we, 1'b0);

        // Random traffic.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 80; k++) begin
                s_rd[k]   = ($urandom_range(0, 9) < 7);
                s_src[k]  = 16'($urandom);
                s_tgt[k]  = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
                s_bank[k] = 1'($urandom);
            end
            run_seq(80, 88);
            model_check(80, 88, $sformatf("rand%0d", r), nw, nr, nd, ns);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
